// File: rtl/zmod_rxalign_if.sv
// Deserializer-side bus of the Zmod receive word aligner: raw words in,
// bitslip request back, registered aligned words out.
interface zmod_rxalign_if #(
   parameter int unsigned W = 8
);
   logic [W-1:0] din;
   logic         bitslip;
   logic [W-1:0] dout;
   logic         dout_valid;

   modport master (
      output din,
      input  bitslip,
      input  dout,
      input  dout_valid
   );

   modport slave (
      input  din,
      output bitslip,
      output dout,
      output dout_valid
   );
endinterface

// File: rtl/zmod_rxalign.sv
// Zmod receive word aligner: hunts for TRAIN with bitslip pulses, then locks and forwards data.
// Optional lock-time mismatch statistics are built when ZMOD_RXALIGN_STATS_EN is defined.
module zmod_rxalign #(
   parameter int unsigned   W          = 8,
   parameter logic [W-1:0]  TRAIN      = 8'h5C,
   parameter int unsigned   SETTLE_CYC = 4,
   parameter int unsigned   MATCH_N    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mmcm_locked,
   input  logic                 resync,
   input  logic                 train,
   zmod_rxalign_if.slave        bus,
   output logic                 aligned,
   output logic [$clog2(W)-1:0] slip_count,
   output logic                 err,
   output logic [15:0]          mismatch_cnt
);

   localparam int unsigned SW = $clog2(W);
   localparam logic [3:0]    SETTLE_LD  = 4'(SETTLE_CYC);
   localparam logic [7:0]    MATCH_LAST = 8'(MATCH_N - 1);
   localparam logic [SW-1:0] SLIP_LAST  = SW'(W - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CHECK,
      SLIP,
      LOCKED
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    settle_q, settle_d;
   logic [7:0]    match_q, match_d;
   logic [SW-1:0] slip_q, slip_d;
   logic          err_q, err_d;
   logic [W-1:0]  dout_q, dout_d;
   logic          valid_q, valid_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         settle_q <= '0;
         match_q  <= '0;
         slip_q   <= '0;
         err_q    <= 1'b0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         match_q  <= match_d;
         slip_q   <= slip_d;
         err_q    <= err_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      match_d  = match_q;
      slip_d   = slip_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (mmcm_locked) begin
               state_d  = SETTLE;
               settle_d = SETTLE_LD;
            end
         end
         SETTLE: begin
            settle_d = settle_q - 4'd1;
            if (settle_q == 4'd1) begin
               state_d = CHECK;
               match_d = '0;
            end
         end
         CHECK: begin
            if (bus.din == TRAIN) begin
               if (match_q == MATCH_LAST) state_d = LOCKED;
               else                       match_d = match_q + 8'd1;
            end else begin
               state_d = SLIP;
            end
         end
         SLIP: begin
            state_d  = SETTLE;
            settle_d = SETTLE_LD;
            if (slip_q == SLIP_LAST) begin
               slip_d = '0;
               err_d  = 1'b1;
            end else begin
               slip_d = slip_q + 1'b1;
            end
         end
         LOCKED: begin
            if (resync) begin
               state_d  = SETTLE;
               settle_d = SETTLE_LD;
            end
         end
         default: state_d = IDLE;
      endcase
      // Clock loss overrides everything, including an err set by a slip in flight.
      if (!mmcm_locked) begin
         state_d = IDLE;
         err_d   = err_q;
      end
      if (state_d == IDLE) slip_d = '0;
      // Data is only forwarded for cycles that are LOCKED on both sides of the edge.
      valid_d = (state_q == LOCKED) && (state_d == LOCKED);
      dout_d  = valid_d ? bus.din : '0;
   end

   always_comb begin
      bus.bitslip = (state_q == SLIP);
      aligned     = (state_q == LOCKED);
   end

   assign slip_count     = slip_q;
   assign err            = err_q;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = valid_q;

`ifdef ZMOD_RXALIGN_STATS_EN
   logic [15:0] mm_q, mm_d;

   always_comb begin
      mm_d = mm_q;
      if ((state_d == LOCKED) && (state_q != LOCKED)) begin
         mm_d = '0;
      end else if ((state_q == LOCKED) && train && (bus.din != TRAIN) && (mm_q != '1)) begin
         mm_d = mm_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) mm_q <= '0;
      else     mm_q <= mm_d;
   end

   assign mismatch_cnt = mm_q;
`else
   logic unused_train;
   assign unused_train = train;
   assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_zmod_rxalign.sv
// Randomized self-checking bench for zmod_rxalign against a rotating-deserializer model
// and closed-form lock/slip timing arithmetic.
module tb_zmod_rxalign;

   localparam int unsigned  W         = 8;
   localparam logic [W-1:0] TRAIN     = 8'h5C;
   localparam int unsigned  SETTLE    = 4;
   localparam int unsigned  MATCH     = 16;
   localparam int           LOCK_LAT  = 1 + SETTLE + MATCH;
   localparam int           SLIP_COST = SETTLE + 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, mmcm_locked, resync, train;
   logic        aligned, err;
   logic [2:0]  slip_count;
   logic [15:0] mismatch_cnt;

   zmod_rxalign_if #(.W(W)) bus ();

   zmod_rxalign #(
      .W          (W),
      .TRAIN      (TRAIN),
      .SETTLE_CYC (SETTLE),
      .MATCH_N    (MATCH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mmcm_locked  (mmcm_locked),
      .resync       (resync),
      .train        (train),
      .bus          (bus),
      .aligned      (aligned),
      .slip_count   (slip_count),
      .err          (err),
      .mismatch_cnt (mismatch_cnt)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc, nslips, last_pulse, min_gap, width_err, rot, exp_mm;
   bit zero_mode, inject, prev_bs, ever_al, lost_lock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
      logic [W-1:0] t;
      t = v;
      for (int i = 0; i < r; i++) t = {t[W-2:0], t[W-1]};
      return t;
   endfunction

   task automatic drive();
      bus.din = inject ? '1 : (zero_mode ? '0 : rotl(TRAIN, rot));
   endtask

   // One clock: sample after the edge, apply any bitslip to the line model, re-drive din.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.bitslip === 1'b1) begin
         nslips++;
         if (prev_bs) width_err++;
         if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
         last_pulse = cyc;
         rot = (rot + 1) % W;
      end
      prev_bs = (bus.bitslip === 1'b1);
      if (aligned === 1'b1) ever_al = 1'b1;
      else                  lost_lock = 1'b1;
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1; mmcm_locked = 1'b0; resync = 1'b0; train = 1'b0;
      inject = 1'b0; zero_mode = 1'b0; rot = 0;
      drive();
      tick();
      tick();
      rst = 1'b0;
      nslips = 0; last_pulse = -1; min_gap = 1000; width_err = 0;
      prev_bs = 1'b0; ever_al = 1'b0; exp_mm = 0;
   endtask

   // Edges counted from the first edge that sees the current inputs until aligned is high.
   task automatic count_to_lock(input bit noise, output int edges);
      edges = 0;
      do begin
         tick();
         edges++;
         if (noise && aligned !== 1'b1) begin
            resync = ($urandom_range(0, 3) == 0);
            train  = 1'($urandom_range(0, 1));
         end
      end while (aligned !== 1'b1 && edges < 400);
      resync = 1'b0;
      if (aligned !== 1'b1) check("lock_timeout", {31'd0, aligned}, 32'd1);
   endtask

   task automatic hunt(output int edges);
      mmcm_locked = 1'b1;
      count_to_lock(1'b1, edges);
   endtask

   task automatic wait_slips(input int n);
      int budget;
      budget = 0;
      while (nslips < n && budget < 400) begin
         tick();
         budget++;
      end
      if (nslips < n) check("slip_timeout", nslips, n);
      tick();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int e, e2, ns, r0;
      int pos [$];
      cyc = 0;

      // Reset state, including holding mmcm_locked low.
      do_reset();
      for (int i = 0; i < 3; i++) tick();
      check("rst_bitslip", {31'd0, bus.bitslip}, 0);
      check("rst_aligned", {31'd0, aligned}, 0);
      check("rst_slip_count", {29'd0, slip_count}, 0);
      check("rst_err", {31'd0, err}, 0);
      check("rst_dout", {24'd0, bus.dout}, 0);
      check("rst_dout_valid", {31'd0, bus.dout_valid}, 0);
      check("rst_mismatch", {16'd0, mismatch_cnt}, 0);

      // Already-aligned input.
      do_reset();
      hunt(e);
      check("t1_latency", e, LOCK_LAT);
      check("t1_slips", nslips, 0);
      check("t1_slip_count", {29'd0, slip_count}, 0);
      check("t1_valid_first", {31'd0, bus.dout_valid}, 0);
      tick();
      check("t1_dout", {24'd0, bus.dout}, {24'd0, TRAIN});
      check("t1_dout_valid", {31'd0, bus.dout_valid}, 1);

      // Rotated inputs: 3 bits first, then random rotations.
      for (int t = 0; t < 5; t++) begin
         r0 = (t == 0) ? W - 3 : int'($urandom_range(0, W - 1));
         do_reset();
         rot = r0;
         drive();
         hunt(e);
         ns = (W - r0) % W;
         check("t2_latency", e, LOCK_LAT + SLIP_COST * ns);
         check("t2_slips", nslips, ns);
         check("t2_slip_count", {29'd0, slip_count}, ns);
         check("t2_err", {31'd0, err}, 0);
         check("t2_pulse_width", width_err, 0);
         if (ns > 1) check("t2_pulse_gap", {31'd0, min_gap >= SLIP_COST}, 1);
      end

      // Never-matching input: wrap and sticky err, hunting continues.
      do_reset();
      zero_mode = 1'b1;
      drive();
      mmcm_locked = 1'b1;
      wait_slips(W - 1);
      check("t3_count_before_wrap", {29'd0, slip_count}, W - 1);
      check("t3_err_before_wrap", {31'd0, err}, 0);
      wait_slips(W);
      check("t3_count_wrapped", {29'd0, slip_count}, 0);
      check("t3_err_set", {31'd0, err}, 1);
      wait_slips(W + 1);
      check("t3_count_after", {29'd0, slip_count}, 1);
      check("t3_err_sticky", {31'd0, err}, 1);
      check("t3_never_aligned", {31'd0, ever_al}, 0);

      // Clock loss while locked, then relock.
      do_reset();
      rot = W - 2;
      drive();
      hunt(e);
      check("t4_slip_count", {29'd0, slip_count}, 2);
      mmcm_locked = 1'b0;
      tick();
      check("t4_aligned_drop", {31'd0, aligned}, 0);
      check("t4_valid_drop", {31'd0, bus.dout_valid}, 0);
      check("t4_dout_zero", {24'd0, bus.dout}, 0);
      check("t4_slip_clear", {29'd0, slip_count}, 0);
      mmcm_locked = 1'b1;
      count_to_lock(1'b0, e);
      check("t4_relock", e, LOCK_LAT);

      // resync together with clock loss goes to IDLE.
      do_reset();
      rot = W - 2;
      drive();
      hunt(e);
      resync = 1'b1;
      mmcm_locked = 1'b0;
      tick();
      resync = 1'b0;
      mmcm_locked = 1'b1;
      check("t5_prio_aligned", {31'd0, aligned}, 0);
      check("t5_prio_slip_clear", {29'd0, slip_count}, 0);
      count_to_lock(1'b0, e);
      check("t5_prio_relock", e, LOCK_LAT);

      // resync alone keeps slip_count and re-enters SETTLE.
      do_reset();
      rot = W - 2;
      drive();
      hunt(e);
      resync = 1'b1;
      tick();
      resync = 1'b0;
      check("t5_resync_aligned", {31'd0, aligned}, 0);
      check("t5_resync_slip_kept", {29'd0, slip_count}, 2);
      count_to_lock(1'b0, e2);
      check("t5_resync_relock", e2 + 1, LOCK_LAT);

      // Mismatch statistics while locked.
      do_reset();
      hunt(e);
      train = 1'b1;
      pos.delete();
      while (pos.size() < 3) begin
         int p;
         bit dup;
         p = int'($urandom_range(0, 23));
         dup = 1'b0;
         foreach (pos[k]) if (pos[k] == p) dup = 1'b1;
         if (!dup) pos.push_back(p);
      end
      lost_lock = 1'b0;
      for (int i = 0; i < 24; i++) begin
         inject = 1'b0;
         foreach (pos[k]) if (pos[k] == i) inject = 1'b1;
         drive();
         if (train && bus.din != TRAIN) exp_mm++;
         tick();
      end
      inject = 1'b0;
      drive();
`ifdef ZMOD_RXALIGN_STATS_EN
      check("t6_mismatch_3", {16'd0, mismatch_cnt}, exp_mm);
`else
      check("t6_mismatch_off", {16'd0, mismatch_cnt}, 0);
`endif
      for (int i = 0; i < 32; i++) begin
         train  = 1'($urandom_range(0, 1));
         inject = ($urandom_range(0, 3) == 0);
         drive();
         if (train && bus.din != TRAIN) exp_mm++;
         tick();
      end
      inject = 1'b0;
      drive();
      check("t6_lock_kept", {31'd0, lost_lock}, 0);
`ifdef ZMOD_RXALIGN_STATS_EN
      check("t6_mismatch_rand", {16'd0, mismatch_cnt}, exp_mm);
`else
      check("t6_mismatch_rand_off", {16'd0, mismatch_cnt}, 0);
`endif
      resync = 1'b1;
      tick();
      resync = 1'b0;
      count_to_lock(1'b0, e);
      check("t6_relock", e + 1, LOCK_LAT);
      check("t6_mismatch_clear", {16'd0, mismatch_cnt}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
